cp0_exception_unit: RTL and testbench

Parametrised successor to the MEM-stage exception decoder. It merges exception prioritisation with a registered CP0 file (BadVAddr, Count, Compare, Status, Cause, EPC) and an N-line hardware interrupt front end with an internal timer interrupt. It commits the exception or ERET seen in MEM, then drives pipeline flush and the redirect PC. It sits beside the MEM stage and serves MTC0/MFC0.

---
 rtl/cp0_exception_unit.sv | 191 +++++++++++++++++++
 tb/tb_cp0_exception_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
// MEM-stage exception prioritisation, CP0 register file (BadVAddr, Count,
// Compare, Status, Cause, EPC), hardware/timer interrupt front end, and
// flush/redirect generation for exception and ERET commits.
module cp0_exception_unit #(
  parameter int          HW_INT_NUM   = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int          COUNT_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validM,
  input  logic                  stallM,
  input  logic [31:0]           pcM,
  input  logic [31:0]           memAddrM,
  input  logic                  inDelaySlotM,
  input  logic                  isSyscallM,
  input  logic                  isBreakM,
  input  logic                  isEretM,
  input  logic                  isLoadAddrErrM,
  input  logic                  isStoreAddrErrM,
  input  logic                  isOverflowM,
  input  logic                  isReservedM,
  input  logic [HW_INT_NUM-1:0] hwInt,
  input  logic                  cp0WeM,
  input  logic [4:0]            cp0WaddrM,
  input  logic [31:0]           cp0WdataM,
  input  logic [4:0]            cp0RaddrM,
  output logic [31:0]           cp0RdataM,
  output logic                  flush,
  output logic [31:0]           redirectPC,
  output logic [4:0]            excCode,
  output logic                  timerInt,
  output logic [31:0]           statusOut,
  output logic [31:0]           causeOut,
  output logic [31:0]           epcOut
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM, EXL, IE
  localparam logic [4:0]  NO_EXC       = 5'h1f;

  logic [31:0] status_q, status_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        bd_q, bd_d, ti_q, ti_d, div_q, div_d;
  logic [5:0]  ip_hw_q, ip_hw_d;      // Cause.IP[7:2]
  logic [1:0]  ip_sw_q, ip_sw_d;      // Cause.IP[1:0] (software)
  logic [4:0]  cause_code_q, cause_code_d, exc_out_q, exc_out_d;

  logic [5:0]  hw_ext;
  logic [31:0] cause_val;
  logic        commit, int_pending, fetch_err, count_tick;
  logic        exc_take, eret_take, mtc0_en, bad_from_pc, bad_from_mem;
  logic [4:0]  exc_code;

  // Line 5 only exists when all six lines are present; it shares IP7 with the timer.
  if (HW_INT_NUM >= 6) begin : g_hw_full
    assign hw_ext = hwInt[5:0];
  end else begin : g_hw_part
    assign hw_ext = {{(6 - HW_INT_NUM){1'b0}}, hwInt};
  end

  assign cause_val   = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, cause_code_q, 2'b0};
  assign commit      = validM & ~stallM;
  assign int_pending = (|({ip_hw_q, ip_sw_q} & status_q[15:8])) & status_q[0] & ~status_q[1];
  assign fetch_err   = |pcM[1:0];
  assign count_tick  = (COUNT_DIV == 1) ? 1'b1 : div_q;

  // Prioritise the exception sources of the committing instruction.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    exc_take     = 1'b0;
    exc_code     = NO_EXC;
    bad_from_pc  = 1'b0;
    bad_from_mem = 1'b0;
    if (commit) begin
      exc_take = 1'b1;
      if (int_pending)          exc_code = 5'd0;
      else if (fetch_err)       begin exc_code = 5'd4; bad_from_pc = 1'b1; end
      else if (isReservedM)     exc_code = 5'd10;
      else if (isOverflowM)     exc_code = 5'd12;
      else if (isSyscallM)      exc_code = 5'd8;
      else if (isBreakM)        exc_code = 5'd9;
      else if (isLoadAddrErrM)  begin exc_code = 5'd4; bad_from_mem = 1'b1; end
      else if (isStoreAddrErrM) begin exc_code = 5'd5; bad_from_mem = 1'b1; end
      else                      exc_take = 1'b0;
    end
  end

  assign eret_take  = commit & isEretM & ~exc_take;
  assign mtc0_en    = cp0WeM & ~exc_take & ~eret_take;
  assign flush      = ~rst & (exc_take | eret_take);
  assign redirectPC = exc_take ? EXC_VECTOR : epc_q;

  // Next-state for the CP0 file: commits first, otherwise MTC0 writes.
  always_comb begin
    status_d     = status_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;
    compare_d    = compare_q;
    bd_d         = bd_q;
    ip_sw_d      = ip_sw_q;
    cause_code_d = cause_code_q;
    exc_out_d    = exc_out_q;
    ip_hw_d      = {ti_q | hw_ext[5], hw_ext[4:0]};
    div_d        = (COUNT_DIV == 1) ? 1'b0 : ~div_q;
    count_d      = count_tick ? count_q + 32'd1 : count_q;
    ti_d         = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));

    if (exc_take) begin
      epc_d        = inDelaySlotM ? pcM - 32'd4 : pcM;
      bd_d         = inDelaySlotM;
      cause_code_d = exc_code;
      exc_out_d    = exc_code;
      status_d[1]  = 1'b1;
      if (bad_from_pc)  badvaddr_d = pcM;
      if (bad_from_mem) badvaddr_d = memAddrM;
    end else if (eret_take) begin
      status_d[1] = 1'b0;
    end

    if (mtc0_en) begin
      case (cp0WaddrM)
        REG_COUNT:   count_d = cp0WdataM;
        REG_COMPARE: begin compare_d = cp0WdataM; ti_d = 1'b0; end
        REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (cp0WdataM & STATUS_WMASK);
        REG_CAUSE:   ip_sw_d = cp0WdataM[9:8];
        REG_EPC:     epc_d = cp0WdataM;
        default:     ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      status_q     <= RESET_STATUS;
      epc_q        <= '0;
      badvaddr_q   <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      bd_q         <= 1'b0;
      ti_q         <= 1'b0;
      div_q        <= 1'b0;
      ip_hw_q      <= '0;
      ip_sw_q      <= '0;
      cause_code_q <= '0;
      exc_out_q    <= NO_EXC;
    end else begin
      status_q     <= status_d;
      epc_q        <= epc_d;
      badvaddr_q   <= badvaddr_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      bd_q         <= bd_d;
      ti_q         <= ti_d;
      div_q        <= div_d;
      ip_hw_q      <= ip_hw_d;
      ip_sw_q      <= ip_sw_d;
      cause_code_q <= cause_code_d;
      exc_out_q    <= exc_out_d;
    end
  end

  // MFC0 read port: registered values only, unmapped numbers read zero.
  always_comb begin
    cp0RdataM = '0;
    case (cp0RaddrM)
      REG_BADVADDR: cp0RdataM = badvaddr_q;
      REG_COUNT:    cp0RdataM = count_q;
      REG_COMPARE:  cp0RdataM = compare_q;
      REG_STATUS:   cp0RdataM = status_q;
      REG_CAUSE:    cp0RdataM = cause_val;
      REG_EPC:      cp0RdataM = epc_q;
      default:      ;
    endcase
  end

  assign excCode   = exc_out_q;
  assign timerInt  = ti_q;
  assign statusOut = status_q;
  assign causeOut  = cause_val;
  assign epcOut    = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: a behavioural CP0 model checked on
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_cp0_exception_unit;

  localparam int          HWN     = 5;
  localparam int          CDIV    = 2;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [31:0] RST_ST  = 32'h0040_0000;

  logic        clk = 1'b0, rst;
  logic        validM, stallM, inDelaySlotM;
  logic [31:0] pcM, memAddrM;
  logic        isSyscallM, isBreakM, isEretM, isLoadAddrErrM, isStoreAddrErrM, isOverflowM, isReservedM;
  logic [HWN-1:0] hwInt;
  logic        cp0WeM;
  logic [4:0]  cp0WaddrM, cp0RaddrM;
  logic [31:0] cp0WdataM, cp0RdataM;
  logic        flush, timerInt;
  logic [31:0] redirectPC, statusOut, causeOut, epcOut;
  logic [4:0]  excCode;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rd_idx = 0;

  cp0_exception_unit #(.HW_INT_NUM(HWN), .EXC_VECTOR(EXC_VEC), .RESET_STATUS(RST_ST), .COUNT_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .validM(validM), .stallM(stallM), .pcM(pcM), .memAddrM(memAddrM),
    .inDelaySlotM(inDelaySlotM), .isSyscallM(isSyscallM), .isBreakM(isBreakM), .isEretM(isEretM),
    .isLoadAddrErrM(isLoadAddrErrM), .isStoreAddrErrM(isStoreAddrErrM), .isOverflowM(isOverflowM),
    .isReservedM(isReservedM), .hwInt(hwInt), .cp0WeM(cp0WeM), .cp0WaddrM(cp0WaddrM),
    .cp0WdataM(cp0WdataM), .cp0RaddrM(cp0RaddrM), .cp0RdataM(cp0RdataM), .flush(flush),
    .redirectPC(redirectPC), .excCode(excCode), .timerInt(timerInt), .statusOut(statusOut),
    .causeOut(causeOut), .epcOut(epcOut)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
  logic        m_bd, m_ti;
  logic [7:0]  m_ip;
  logic [4:0]  m_code, m_exc_out;
  int          m_edges;

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_ip, 1'b0, m_code, 2'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Walk the priority list top-down; the first raised source wins.
  function automatic void m_decide(output bit take, output logic [4:0] code, output bit eret, output int badsrc);
    bit pend, commit;
    bit src[8];
    int codes[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    int bads[8]  = '{0, 1, 0, 0, 0, 0, 2, 2};
    commit = validM && !stallM;
    pend   = ((m_ip & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1];
    src    = '{pend, pcM[1:0] != 2'b00, isReservedM, isOverflowM, isSyscallM, isBreakM,
               isLoadAddrErrM, isStoreAddrErrM};
    take = 1'b0; code = 5'h1f; badsrc = 0;
    for (int i = 0; i < 8; i++)
      if (!take && src[i]) begin take = 1'b1; code = 5'(codes[i]); badsrc = bads[i]; end
    take = take && commit;
    eret = commit && isEretM && !take;
  endfunction

  always @(posedge clk) begin
    bit take, eret, mtc0, tick, ti_set;
    logic [4:0] code;
    int badsrc;
    m_decide(take, code, eret, badsrc);
    if (rst) begin
      m_status = RST_ST; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
      m_bd = 0; m_ti = 0; m_ip = 0; m_code = 0; m_exc_out = 5'h1f; m_edges = 0;
    end else begin
      m_edges++;
      tick   = (m_edges % CDIV) == 0;
      ti_set = (m_count == m_compare) && (m_compare != 0);
      mtc0   = cp0WeM && !take && !eret;
      m_ip   = {m_ti, hwInt, m_ip[1:0]};
      m_ti   = m_ti || ti_set;
      m_count = m_count + (tick ? 32'd1 : 32'd0);
      if (take) begin
        m_epc = inDelaySlotM ? pcM - 4 : pcM;
        m_bd = inDelaySlotM; m_code = code; m_exc_out = code; m_status[1] = 1'b1;
        if (badsrc == 1) m_bad = pcM;
        if (badsrc == 2) m_bad = memAddrM;
      end else if (eret) m_status[1] = 1'b0;
      if (mtc0) begin
        case (cp0WaddrM)
          5'd9:  m_count = cp0WdataM;
          5'd11: begin m_compare = cp0WdataM; m_ti = 1'b0; end
          5'd12: m_status = {m_status[31:16], cp0WdataM[15:8], m_status[7:2], cp0WdataM[1:0]};
          5'd13: m_ip[1:0] = cp0WdataM[9:8];
          5'd14: m_epc = cp0WdataM;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit take, eret;
    logic [4:0] code;
    int badsrc;
    if (chk_en) begin
      m_decide(take, code, eret, badsrc);
      check("m_flush", {31'b0, flush}, {31'b0, !rst && (take || eret)});
      if (!rst && (take || eret)) check("m_redirect", redirectPC, take ? EXC_VEC : m_epc);
      check("m_excCode", {27'b0, excCode}, {27'b0, m_exc_out});
      check("m_timerInt", {31'b0, timerInt}, {31'b0, m_ti});
      check("m_status", statusOut, m_status);
      check("m_cause", causeOut, m_cause());
      check("m_epc", epcOut, m_epc);
      check("m_rdata", cp0RdataM, m_read(cp0RaddrM));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    logic [4:0] rd_list[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    validM = 0; stallM = 0; inDelaySlotM = 0; pcM = 32'hBFC0_0000; memAddrM = 0;
    isSyscallM = 0; isBreakM = 0; isEretM = 0; isLoadAddrErrM = 0; isStoreAddrErrM = 0;
    isOverflowM = 0; isReservedM = 0; cp0WeM = 0; cp0WaddrM = 0; cp0WdataM = 0;
    cp0RaddrM = rd_list[rd_idx % 7]; rd_idx++;
  endtask

  task automatic next();
    @(posedge clk); #1; clr();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0WeM = 1; cp0WaddrM = a; cp0WdataM = d; next();
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    cp0RaddrM = a; #1; check(name, cp0RdataM, exp);
  endtask

  initial begin
    int n;
    hwInt = '0; rst = 1; clr();
    repeat (2) @(posedge clk);
    #1; chk_en = 1;
    check("rst_status", statusOut, 32'h0040_0000);
    check("rst_cause", causeOut, 32'h0);
    check("rst_epc", epcOut, 32'h0);
    check("rst_excCode", {27'b0, excCode}, 32'h1f);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_timerInt", {31'b0, timerInt}, 32'h0);
    rst = 0; next();

    // Overflow, not in a delay slot.
    validM = 1; pcM = 32'hBFC0_0100; isOverflowM = 1;
    @(negedge clk);
    check("ov_flush", {31'b0, flush}, 32'h1);
    check("ov_redirect", redirectPC, 32'hBFC0_0380);
    next();
    check("ov_epc", epcOut, 32'hBFC0_0100);
    check("ov_code", {27'b0, causeOut[6:2]}, 32'd12);
    check("ov_exl", {31'b0, statusOut[1]}, 32'h1);
    check("ov_bd", {31'b0, causeOut[31]}, 32'h0);
    check("ov_excCode", {27'b0, excCode}, 32'd12);

    // Store address error in a delay slot.
    validM = 1; pcM = 32'hBFC0_0208; inDelaySlotM = 1; memAddrM = 32'h8000_0003; isStoreAddrErrM = 1;
    next();
    check("ades_epc", epcOut, 32'hBFC0_0204);
    check("ades_bd", {31'b0, causeOut[31]}, 32'h1);
    check("ades_excCode", {27'b0, excCode}, 32'd5);
    rd_check("ades_badv", 5'd8, 32'h8000_0003);

    // Misaligned fetch beats syscall.
    validM = 1; pcM = 32'hBFC0_0102; isSyscallM = 1;
    next();
    check("adel_excCode", {27'b0, excCode}, 32'd4);
    rd_check("adel_badv", 5'd8, 32'hBFC0_0102);

    // Hardware interrupt on IP2.
    mtc0(5'd12, 32'h0000_0401);
    check("int_status", statusOut, 32'h0040_0401);
    hwInt[0] = 1'b1; next();
    validM = 1; pcM = 32'hBFC0_0300;
    @(negedge clk);
    check("int_flush", {31'b0, flush}, 32'h1);
    next();
    check("int_excCode", {27'b0, excCode}, 32'd0);
    check("int_epc", epcOut, 32'hBFC0_0300);
    validM = 1; pcM = 32'hBFC0_0304;   // EXL=1 now: masked
    @(negedge clk);
    check("int_exl_noflush", {31'b0, flush}, 32'h0);
    next();
    hwInt = '0; next();

    // Timer interrupt.
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    rd_check("ti_compare", 5'd11, 32'd10);
    n = 0;
    while (!timerInt && n < 60) begin next(); n++; end
    check("ti_seen", {31'b0, timerInt}, 32'h1);
    next();
    validM = 1; pcM = 32'hBFC0_0400;
    @(negedge clk);
    check("ti_int_flush", {31'b0, flush}, 32'h1);
    next();
    check("ti_int_excCode", {27'b0, excCode}, 32'd0);
    check("ti_ip7", {31'b0, causeOut[15]}, 32'h1);
    mtc0(5'd11, 32'h0);
    check("ti_cleared", {31'b0, timerInt}, 32'h0);

    // Count wrap.
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd_check("cnt_max", 5'd9, 32'hFFFF_FFFF);
    next(); next();
    rd_check("cnt_wrap", 5'd9, 32'h0);

    // ERET, stalled then committed.
    mtc0(5'd14, 32'hBFC0_0200);
    mtc0(5'd12, 32'h0000_0002);
    validM = 1; stallM = 1; isEretM = 1;
    @(negedge clk);
    check("eret_stall_flush", {31'b0, flush}, 32'h0);
    next();
    check("eret_stall_status", statusOut, 32'h0040_0002);
    validM = 1; isEretM = 1;
    @(negedge clk);
    check("eret_flush", {31'b0, flush}, 32'h1);
    check("eret_redirect", redirectPC, 32'hBFC0_0200);
    next();
    check("eret_exl", {31'b0, statusOut[1]}, 32'h0);

    // Reset while an exception is presented.
    rst = 1; validM = 1; pcM = 32'hBFC0_0500; isBreakM = 1;
    @(negedge clk);
    check("rst_mid_flush", {31'b0, flush}, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_status", statusOut, 32'h0040_0000);
    check("rst_mid_excCode", {27'b0, excCode}, 32'h1f);
    rst = 0; clr();
    repeat (4) next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
